// File: rtl/output_xbar.sv
// output_xbar: routes beats from NUM_BANKS FV bank controllers to NUM_PE Edge
// PEs. Each PE has its own round-robin arbiter with packet lock and a small
// FIFO. Beats whose tag is out of range are accepted, dropped, and flagged one
// cycle later on tag_err.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   bank_valid/sos/eos   [NB]  per-bank beat valid and stream flags
//   bank_pe_tag   [NB*TAG_W]   destination PE index per bank
//   bank_data    [NB*DATA_W]   FV_data per bank
//   bank_ready           [NB]  combinational accept (grant or bad-tag drop)
//   pe_valid/sos/eos     [NP]  head-of-FIFO beat per PE (zero when not valid)
//   pe_data      [NP*DATA_W]   head-of-FIFO data per PE
//   pe_ready             [NP]  PE consumes the head beat
//   tag_err                    registered pulse after an out-of-range tag drop
module output_xbar #(
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned TAG_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_BANKS-1:0]          bank_valid,
  input  logic [NUM_BANKS*TAG_W-1:0]    bank_pe_tag,
  input  logic [NUM_BANKS-1:0]          bank_sos,
  input  logic [NUM_BANKS-1:0]          bank_eos,
  input  logic [NUM_BANKS*DATA_W-1:0]   bank_data,
  output logic [NUM_BANKS-1:0]          bank_ready,
  output logic [NUM_PE-1:0]             pe_valid,
  output logic [NUM_PE-1:0]             pe_sos,
  output logic [NUM_PE-1:0]             pe_eos,
  output logic [NUM_PE*DATA_W-1:0]      pe_data,
  input  logic [NUM_PE-1:0]             pe_ready,
  output logic                          tag_err
);

  localparam int unsigned BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned ENT_W = DATA_W + 2;

  logic [NUM_BANKS-1:0] bad_tag;
  logic [NUM_BANKS-1:0] bank_gnt;
  logic [NUM_PE-1:0]    gnt;
  logic [BW-1:0]        gnt_bank  [NUM_PE];
  logic [ENT_W-1:0]     push_ent  [NUM_PE];
  logic [NUM_PE-1:0]    full;
  logic [NUM_PE-1:0]    pop;

  logic [BW-1:0]        rr_q        [NUM_PE];
  logic [BW-1:0]        rr_d        [NUM_PE];
  logic [NUM_PE-1:0]    lock_q, lock_d;
  logic [BW-1:0]        lock_bank_q [NUM_PE];
  logic [BW-1:0]        lock_bank_d [NUM_PE];
  logic [AW-1:0]        wr_q [NUM_PE];
  logic [AW-1:0]        wr_d [NUM_PE];
  logic [AW-1:0]        rd_q [NUM_PE];
  logic [AW-1:0]        rd_d [NUM_PE];
  logic [CW-1:0]        cnt_q [NUM_PE];
  logic [CW-1:0]        cnt_d [NUM_PE];
  logic [ENT_W-1:0]     mem_q [NUM_PE][FIFO_DEPTH];
  logic                 tag_err_q, tag_err_d;

  // Out-of-range tag detection
  always_comb begin
    bad_tag = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bad_tag[b] = 32'(bank_pe_tag[b*TAG_W +: TAG_W]) >= NUM_PE;
    end
  end

  // Per-PE arbitration. A bank carries a single tag, so it can match at most
  // one PE and the one-grant-per-bank rule follows without extra logic.
  always_comb begin
    logic        found;
    int unsigned b;
    int unsigned k;
    gnt      = '0;
    bank_gnt = '0;
    for (int unsigned p = 0; p < NUM_PE; p++) begin
      found       = 1'b0;
      gnt_bank[p] = '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        b = (32'(rr_q[p]) + i) % NUM_BANKS;
        if (!found && bank_valid[b] && !bad_tag[b] &&
            32'(bank_pe_tag[b*TAG_W +: TAG_W]) == p &&
            (!lock_q[p] || 32'(lock_bank_q[p]) == b)) begin
          found       = 1'b1;
          gnt_bank[p] = BW'(b);
        end
      end
      // Fullness is judged on start-of-cycle occupancy only.
      gnt[p] = found && !full[p] && !reset;
      k = 32'(gnt_bank[p]);
      push_ent[p] = {bank_sos[k], bank_eos[k], bank_data[k*DATA_W +: DATA_W]};
      if (gnt[p]) bank_gnt[k] = 1'b1;
    end
  end

  always_comb begin
    bank_ready = reset ? '0 : (bank_gnt | (bank_valid & bad_tag));
    tag_err_d  = !reset && |(bank_valid & bad_tag);
  end

  // Next-state: round-robin pointer, packet lock, FIFO pointers
  always_comb begin
    int unsigned k;
    for (int unsigned p = 0; p < NUM_PE; p++) begin
      rr_d[p]        = rr_q[p];
      lock_d[p]      = lock_q[p];
      lock_bank_d[p] = lock_bank_q[p];
      wr_d[p]        = wr_q[p];
      rd_d[p]        = rd_q[p];
      cnt_d[p]       = cnt_q[p];
      k = 32'(gnt_bank[p]);
      if (gnt[p]) begin
        wr_d[p] = wr_q[p] + AW'(1);
        if (lock_q[p]) begin
          if (bank_eos[k]) begin
            lock_d[p] = 1'b0;
            rr_d[p]   = (k == NUM_BANKS - 1) ? '0 : gnt_bank[p] + BW'(1);
          end
        end else begin
          rr_d[p] = (k == NUM_BANKS - 1) ? '0 : gnt_bank[p] + BW'(1);
          if (bank_sos[k] && !bank_eos[k]) begin
            lock_d[p]      = 1'b1;
            lock_bank_d[p] = gnt_bank[p];
          end
        end
      end
      if (pop[p]) rd_d[p] = rd_q[p] + AW'(1);
      case ({gnt[p], pop[p]})
        2'b10:   cnt_d[p] = cnt_q[p] + CW'(1);
        2'b01:   cnt_d[p] = cnt_q[p] - CW'(1);
        default: cnt_d[p] = cnt_q[p];
      endcase
    end
  end

  // Head-of-FIFO outputs, forced to zero when empty or in reset
  always_comb begin
    logic [ENT_W-1:0] ent;
    pe_valid = '0;
    pe_sos   = '0;
    pe_eos   = '0;
    pe_data  = '0;
    pop      = '0;
    full     = '0;
    for (int unsigned p = 0; p < NUM_PE; p++) begin
      full[p]     = cnt_q[p] == CW'(FIFO_DEPTH);
      pe_valid[p] = (cnt_q[p] != '0) && !reset;
      ent         = pe_valid[p] ? mem_q[p][rd_q[p]] : '0;
      pe_sos[p]   = ent[ENT_W-1];
      pe_eos[p]   = ent[ENT_W-2];
      pe_data[p*DATA_W +: DATA_W] = ent[DATA_W-1:0];
      pop[p]      = pe_valid[p] && pe_ready[p];
    end
  end

  assign tag_err = tag_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q    <= '0;
      tag_err_q <= 1'b0;
      for (int unsigned p = 0; p < NUM_PE; p++) begin
        rr_q[p]        <= '0;
        lock_bank_q[p] <= '0;
        wr_q[p]        <= '0;
        rd_q[p]        <= '0;
        cnt_q[p]       <= '0;
      end
    end else begin
      lock_q    <= lock_d;
      tag_err_q <= tag_err_d;
      for (int unsigned p = 0; p < NUM_PE; p++) begin
        rr_q[p]        <= rr_d[p];
        lock_bank_q[p] <= lock_bank_d[p];
        wr_q[p]        <= wr_d[p];
        rd_q[p]        <= rd_d[p];
        cnt_q[p]       <= cnt_d[p];
      end
    end
  end

  // FIFO storage needs no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NUM_PE; p++) begin
      if (gnt[p]) mem_q[p][wr_q[p]] <= push_ent[p];
    end
  end

endmodule

// File: tb/tb_output_xbar.sv
// Directed bench for output_xbar: reset, conflict round-robin, packet lock,
// backpressure, parallel routing, bad tag (NUM_PE=3 instance), reset mid-packet.
module tb_output_xbar;
  localparam int NB = 4;
  localparam int NP = 4;
  localparam int NP3 = 3;
  localparam int DW = 64;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NB-1:0]    bank_valid, bank_sos, bank_eos, bank_ready;
  logic [NB*TW-1:0] bank_pe_tag;
  logic [NB*DW-1:0] bank_data;
  logic [NP-1:0]    pe_valid, pe_sos, pe_eos, pe_ready;
  logic [NP*DW-1:0] pe_data;
  logic             tag_err;

  logic [NB-1:0]     b3_valid, b3_sos, b3_eos, b3_ready;
  logic [NB*TW-1:0]  b3_tag;
  logic [NB*DW-1:0]  b3_data;
  logic [NP3-1:0]    b3_pe_valid, b3_pe_sos, b3_pe_eos, b3_pe_ready;
  logic [NP3*DW-1:0] b3_pe_data;
  logic              b3_tag_err;

  output_xbar #(.NUM_BANKS(NB), .NUM_PE(NP), .DATA_W(DW), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset),
    .bank_valid(bank_valid), .bank_pe_tag(bank_pe_tag), .bank_sos(bank_sos),
    .bank_eos(bank_eos), .bank_data(bank_data), .bank_ready(bank_ready),
    .pe_valid(pe_valid), .pe_sos(pe_sos), .pe_eos(pe_eos), .pe_data(pe_data),
    .pe_ready(pe_ready), .tag_err(tag_err)
  );

  output_xbar #(.NUM_BANKS(NB), .NUM_PE(NP3), .DATA_W(DW), .FIFO_DEPTH(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .bank_valid(b3_valid), .bank_pe_tag(b3_tag), .bank_sos(b3_sos),
    .bank_eos(b3_eos), .bank_data(b3_data), .bank_ready(b3_ready),
    .pe_valid(b3_pe_valid), .pe_sos(b3_pe_sos), .pe_eos(b3_pe_eos), .pe_data(b3_pe_data),
    .pe_ready(b3_pe_ready), .tag_err(b3_tag_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input int b, input logic v, input int tag, input logic s,
                       input logic e, input logic [63:0] d);
    bank_valid[b]          = v;
    bank_pe_tag[b*TW +: TW] = TW'(tag);
    bank_sos[b]            = s;
    bank_eos[b]            = e;
    bank_data[b*DW +: DW]  = d;
  endtask

  task automatic idle();
    bank_valid = '0; bank_sos = '0; bank_eos = '0; bank_pe_tag = '0; bank_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] pdat(input int p);
    return pe_data[p*DW +: DW];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    pe_ready = '1;
    b3_valid = '0; b3_sos = '0; b3_eos = '0; b3_tag = '0; b3_data = '0; b3_pe_ready = '1;

    // Reset: inputs active but nothing accepted or shown
    @(negedge clk);
    for (int b = 0; b < NB; b++) drive(b, 1'b1, 0, 1'b1, 1'b1, 64'hF0 + 64'(b));
    #1;
    check("rst_ready", 64'(bank_ready), 64'h0);
    check("rst_pe_valid", 64'(pe_valid), 64'h0);
    tick();
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("post_rst_valid", 64'(pe_valid), 64'h0);
    check("post_rst_tag_err", 64'(tag_err), 64'h0);

    // Conflict: four banks to PE 2, round-robin 0,1,2,3
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < NB; b++) drive(b, 1'b1, 2, 1'b1, 1'b1, 64'hA0 + 64'(b));
      #1;
      check($sformatf("conf_ready%0d", c), 64'(bank_ready), 64'(1) << c);
      if (c == 0) check("conf_valid0", 64'(pe_valid), 64'h0);
      else begin
        check($sformatf("conf_pe_valid%0d", c), 64'(pe_valid), 64'h4);
        check($sformatf("conf_data%0d", c), pdat(2), 64'hA0 + 64'(c - 1));
      end
      tick();
    end
    idle();
    #1;
    check("conf_data4", pdat(2), 64'hA3);
    check("conf_flags4", 64'({pe_sos[2], pe_eos[2]}), 64'h3);
    tick();
    check("conf_empty_valid", 64'(pe_valid), 64'h0);
    check("conf_empty_data", pdat(2), 64'h0);

    // Packet lock: bank 1 holds PE 0 against bank 0
    drive(1, 1'b1, 0, 1'b1, 1'b0, 64'h11);
    #1;
    check("lk_sos_ready", 64'(bank_ready), 64'h2);
    tick();
    drive(1, 1'b1, 0, 1'b0, 1'b0, 64'h12);
    drive(0, 1'b1, 0, 1'b1, 1'b1, 64'h05);
    #1;
    check("lk_mid_ready", 64'(bank_ready), 64'h2);
    check("lk_sos_data", pdat(0), 64'h11);
    check("lk_sos_flags", 64'({pe_sos[0], pe_eos[0]}), 64'h2);
    tick();
    drive(1, 1'b1, 0, 1'b0, 1'b1, 64'h13);
    #1;
    check("lk_eos_ready", 64'(bank_ready), 64'h2);
    check("lk_mid_data", pdat(0), 64'h12);
    check("lk_mid_flags", 64'({pe_sos[0], pe_eos[0]}), 64'h0);
    tick();
    drive(1, 1'b0, 0, 1'b0, 1'b0, 64'h0);
    #1;
    check("lk_release_ready", 64'(bank_ready), 64'h1);
    check("lk_eos_data", pdat(0), 64'h13);
    check("lk_eos_flags", 64'({pe_sos[0], pe_eos[0]}), 64'h1);
    tick();
    idle();
    #1;
    check("lk_b0_data", pdat(0), 64'h05);
    tick();
    check("lk_empty", 64'(pe_valid), 64'h0);

    // Backpressure: bank 2 streams to PE 3 with pe_ready[3]=0
    pe_ready = 4'b0111;
    for (int c = 0; c < 4; c++) begin
      drive(2, 1'b1, 3, 1'b1, 1'b1, 64'h30 + 64'(c));
      #1;
      check($sformatf("bp_ready%0d", c), 64'(bank_ready), 64'h4);
      tick();
    end
    drive(2, 1'b1, 3, 1'b1, 1'b1, 64'h34);
    #1;
    check("bp_full", 64'(bank_ready), 64'h0);
    check("bp_head", pdat(3), 64'h30);
    tick();
    pe_ready[3] = 1'b1;
    #1;
    check("bp_pop_no_push", 64'(bank_ready), 64'h0);
    tick();
    pe_ready[3] = 1'b0;
    #1;
    check("bp_one_more", 64'(bank_ready), 64'h4);
    check("bp_head_after_pop", pdat(3), 64'h31);
    tick();
    drive(2, 1'b1, 3, 1'b1, 1'b1, 64'h35);
    #1;
    check("bp_full2", 64'(bank_ready), 64'h0);
    tick();
    idle();
    pe_ready = '1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("bp_drain%0d", k), pdat(3), 64'h31 + 64'(k));
      tick();
    end
    check("bp_drained", 64'(pe_valid), 64'h0);

    // Parallel: each bank to a distinct PE
    for (int b = 0; b < NB; b++) drive(b, 1'b1, (b + 1) % NP, 1'b1, 1'b1, 64'h40 + 64'(b));
    #1;
    check("par_ready", 64'(bank_ready), 64'hF);
    tick();
    idle();
    #1;
    check("par_valid", 64'(pe_valid), 64'hF);
    for (int b = 0; b < NB; b++)
      check($sformatf("par_data%0d", b), pdat((b + 1) % NP), 64'h40 + 64'(b));
    tick();
    check("par_empty", 64'(pe_valid), 64'h0);

    // Bad tag on the NUM_PE=3 instance, alongside a good beat to PE 2
    b3_valid = 4'b0011;
    b3_tag   = 8'b0000_1011;
    b3_sos   = 4'b0011;
    b3_eos   = 4'b0011;
    b3_data[63:0]   = 64'hBAD;
    b3_data[127:64] = 64'h77;
    #1;
    check("bt_ready", 64'(b3_ready), 64'h3);
    check("bt_err_early", 64'(b3_tag_err), 64'h0);
    tick();
    b3_valid = '0;
    #1;
    check("bt_err", 64'(b3_tag_err), 64'h1);
    check("bt_pe_valid", 64'(b3_pe_valid), 64'h4);
    check("bt_pe_data", b3_pe_data[2*DW +: DW], 64'h77);
    tick();
    check("bt_err_clear", 64'(b3_tag_err), 64'h0);
    check("bt_pe_empty", 64'(b3_pe_valid), 64'h0);

    // Reset mid-packet: lock and buffered beat discarded
    drive(1, 1'b1, 0, 1'b1, 1'b0, 64'h61);
    #1;
    check("rm_sos_ready", 64'(bank_ready), 64'h2);
    tick();
    reset = 1'b1;
    drive(1, 1'b1, 0, 1'b0, 1'b0, 64'h62);
    #1;
    check("rm_rst_ready", 64'(bank_ready), 64'h0);
    check("rm_rst_valid", 64'(pe_valid), 64'h0);
    tick();
    reset = 1'b0;
    idle();
    drive(2, 1'b1, 0, 1'b1, 1'b0, 64'h71);
    #1;
    check("rm_new_ready", 64'(bank_ready), 64'h4);
    check("rm_cleared", 64'(pe_valid), 64'h0);
    tick();
    drive(2, 1'b1, 0, 1'b0, 1'b1, 64'h73);
    #1;
    check("rm_new_ready2", 64'(bank_ready), 64'h4);
    check("rm_new_data", pdat(0), 64'h71);
    check("rm_new_flags", 64'({pe_sos[0], pe_eos[0]}), 64'h2);
    tick();
    idle();
    #1;
    check("rm_eos_data", pdat(0), 64'h73);
    tick();
    check("rm_empty", 64'(pe_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/output_xbar.md
OUTPUT_XBAR -- requirements
Module: output_xbar

Interface
REQ-001 The block SHALL have parameter NUM_BANKS, default 4, number of FV bank controller sources.
REQ-002 The block SHALL have parameter NUM_PE, default 4, number of Edge PE destinations; TAG_W = max(1, clog2(NUM_PE)).
REQ-003 The block SHALL have parameter DATA_W, default 64, FV_data width.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, per-PE buffer entries; power of two, at least 2.
REQ-005 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: bank_valid  input  NUM_BANKS  per-bank beat valid.
REQ-008 Port: bank_pe_tag  input  NUM_BANKS x TAG_W  destination PE index per bank.
REQ-009 Port: bank_sos / bank_eos  input  NUM_BANKS each  start-of-stream and end-of-stream flags per beat.
REQ-010 Port: bank_data  input  NUM_BANKS x DATA_W  FV_data per bank.
REQ-011 Port: bank_ready  output  NUM_BANKS  beat accepted this cycle when bank_valid and bank_ready are both high; combinational.
REQ-012 Port: pe_valid / pe_sos / pe_eos  output  NUM_PE each  head-of-FIFO beat per PE.
REQ-013 Port: pe_data  output  NUM_PE x DATA_W  head-of-FIFO data per PE.
REQ-014 Port: pe_ready  input  NUM_PE  PE consumes the head beat when pe_valid and pe_ready are both high.
REQ-015 Port: tag_err  output  1  one-cycle pulse, registered, for each cycle in which any out-of-range tag was dropped.

Function
REQ-016 Each PE SHALL have an independent arbiter; its requesters are the banks with bank_valid=1 and bank_pe_tag equal to that PE.
REQ-017 Arbitration SHALL be round-robin: search starts at rr_ptr[p]; on an accepted grant to bank k that is not locked, rr_ptr[p] = (k+1) mod NUM_BANKS.
REQ-018 A PE SHALL grant only when its FIFO is not full at the start of the cycle; a same-cycle pop does not free space for a same-cycle push.
REQ-019 At most one beat per PE SHALL be accepted per cycle; each bank SHALL be granted by at most one PE.
REQ-020 Packet lock: an accepted beat with sos=1 and eos=0 SHALL lock PE p to that bank; while locked, only that bank may win PE p, and rr_ptr[p] is held.
REQ-021 The lock SHALL release on the cycle the locked bank's eos=1 beat is accepted; rr_ptr[p] then advances past that bank.
REQ-022 A beat with sos=1 and eos=1 (single beat) SHALL NOT create a lock.
REQ-023 A tag >= NUM_PE SHALL be treated as follows: bank_ready=1, beat discarded, tag_err=1 on the next cycle.
REQ-024 The FIFO SHALL push {sos, eos, data} on acceptance; pe_valid = FIFO not empty; the FIFO pops on pe_valid and pe_ready.
REQ-025 Latency: a beat accepted in cycle N into an empty FIFO SHALL appear on pe_* in cycle N+1.
REQ-026 Per-PE beat order SHALL equal acceptance order; nothing is ever dropped except out-of-range tags.
REQ-027 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-028 When pe_valid=0, pe_sos, pe_eos and pe_data SHALL be 0.

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL clear all FIFOs, set all rr_ptr to 0, clear all locks and set tag_err=0.
REQ-030 During reset, pe_valid SHALL be 0 and bank_ready SHALL be all 0, whatever the inputs.
REQ-031 Reset asserted mid-packet SHALL discard the buffered beats and the lock; the first cycle after reset behaves as after power-up.

Verification
REQ-032 Conflict, NUM_BANKS=4: banks 0-3 all valid single-beat to PE 2 for 4 cycles, pe_ready=1 -> grants in order 0,1,2,3; pe_valid[2] high cycles 1-4 with data in that order.
REQ-033 Packet lock: bank 1 sends 3 beats to PE 0 (sos, mid, eos) while bank 0 is continuously valid to PE 0 -> bank 1 holds PE 0 for all 3 beats; bank 0 is granted on the cycle after eos is accepted.
REQ-034 Backpressure, FIFO_DEPTH=4: pe_ready[3]=0 while bank 2 streams to PE 3 -> 4 beats accepted, then bank_ready[2]=0; raising pe_ready for one cycle -> exactly one more beat accepted the following cycle.
REQ-035 Parallel: banks 0-3 each target a distinct PE in the same cycle -> all bank_ready=1 and all pe_valid=1 next cycle.
REQ-036 Bad tag, NUM_PE=3: bank 0 sends tag 3 -> bank_ready[0]=1, no PE output, tag_err=1 for one cycle.
REQ-037 Reset mid-packet: reset for 1 cycle after the sos beat -> all pe_valid=0; a new packet from another bank is granted immediately.
